// File: rtl/button_oneshot_bank_pkg.sv
// Shared types and helpers for the button one-shot bank.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_DEB   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_DEB = 2'd3
  } btn_state_e;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/button_oneshot_bank_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, press/repeat pulse
// and a clearable toggle.
module button_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic clr_toggle,
  output logic pulse,
  output logic toggle_q,
  output logic held
);

  localparam int unsigned DW   = clog2_min1(DEBOUNCE_CYCLES);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = clog2_min1(RMAX);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST   = RW'((REPEAT_DELAY  > 0) ? REPEAT_DELAY  - 1 : 0);
  localparam logic [RW-1:0] RP_LAST   = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam bit            REPEAT_EN = (REPEAT_DELAY != 0);
  localparam logic          IDLE_LVL  = ACTIVE_LOW;

  btn_state_e    state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rfirst_q, rfirst_d;
  logic          pulse_q, pulse_d;
  logic          toggle_d;
  logic          act;
  logic          press_acc;
  logic [DW-1:0] dcnt_inc;
  logic [RW-1:0] rcnt_inc;
  logic [RW-1:0] rcnt_lim;

  always_comb begin
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    act      = sync2_q ^ ACTIVE_LOW;
    // Saturating increments: counters hold at all-ones rather than wrapping.
    dcnt_inc = (dcnt_q == '1) ? dcnt_q : dcnt_q + 1'b1;
    rcnt_inc = (rcnt_q == '1) ? rcnt_q : rcnt_q + 1'b1;
    rcnt_lim = rfirst_q ? RD_LAST : RP_LAST;
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    rcnt_d    = rcnt_q;
    rfirst_d  = rfirst_q;
    pulse_d   = 1'b0;
    press_acc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (act) begin
          state_d = PRESS_DEB;
          dcnt_d  = '0;
        end
      end
      PRESS_DEB: begin
        if (!act) begin
          state_d = IDLE;
        end else if (dcnt_q == DB_LAST) begin
          state_d   = PRESSED;
          pulse_d   = 1'b1;
          press_acc = 1'b1;
          rcnt_d    = '0;
          rfirst_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_inc;
        end
      end
      PRESSED: begin
        if (!act) begin
          state_d = RELEASE_DEB;
          dcnt_d  = '0;
        end else if (REPEAT_EN) begin
          if (rcnt_q == rcnt_lim) begin
            pulse_d  = 1'b1;
            rcnt_d   = '0;
            rfirst_d = 1'b0;
          end else begin
            rcnt_d = rcnt_inc;
          end
        end
      end
      RELEASE_DEB: begin
        if (act) begin
          state_d  = PRESSED;
          rcnt_d   = '0;
          rfirst_d = 1'b1;
        end else if (dcnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    // A clear in the same cycle as an accepted press takes priority.
    toggle_d = clr_toggle ? 1'b0 : (toggle_q ^ press_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync1_q  <= IDLE_LVL;
      sync2_q  <= IDLE_LVL;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      rfirst_q <= 1'b1;
      pulse_q  <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      dcnt_q   <= dcnt_d;
      rcnt_q   <= rcnt_d;
      rfirst_q <= rfirst_d;
      pulse_q  <= pulse_d;
      toggle_q <= toggle_d;
    end
  end

  assign pulse = pulse_q;
  assign held  = (state_q == PRESSED) || (state_q == RELEASE_DEB);

endmodule

// File: rtl/button_oneshot_bank.sv
// Bank of N_CH independent debounced push-button channels with one-shot
// press pulses, toggle state and optional auto-repeat.
module button_oneshot_bank #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] clr_toggle,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] toggle_q,
  output logic [N_CH-1:0] held
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in[i]),
      .clr_toggle (clr_toggle[i]),
      .pulse      (pulse[i]),
      .toggle_q   (toggle_q[i]),
      .held       (held[i])
    );
  end

endmodule

// File: tb/tb_button_oneshot_bank.sv
// Scoreboard bench for button_oneshot_bank: expected pulses are queued with
// their clock-edge index; monitors pop and compare whenever a pulse appears.
module tb_button_oneshot_bank;

  typedef struct {
    int unsigned at_edge;
    logic [1:0]  pulse;
    logic [1:0]  toggle;
    logic [1:0]  held;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [1:0] btn0, btn1, clr0, clr1;
  logic [1:0] pulse0, tog0, held0;
  logic [1:0] pulse1, tog1, held1;

  int unsigned edge_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned t0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  button_oneshot_bank #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)
  ) u_dut (
    .clk(clk), .rst(rst0), .btn_in(btn0), .clr_toggle(clr0),
    .pulse(pulse0), .toggle_q(tog0), .held(held0)
  );

  button_oneshot_bank #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) u_dut_rep (
    .clk(clk), .rst(rst1), .btn_in(btn1), .clr_toggle(clr1),
    .pulse(pulse1), .toggle_q(tog1), .held(held1)
  );

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (edge %0d)", name, got, want, edge_cnt);
    end
  endtask

  task automatic cmp_pulse(input string tag, input exp_t e,
                           input logic [1:0] p, input logic [1:0] t, input logic [1:0] h);
    n_checks++;
    if (e.at_edge != edge_cnt || p !== e.pulse || t !== e.toggle || h !== e.held) begin
      n_fail++;
      $display("FAIL %s_pulse: edge %0d pulse %b toggle %b held %b, expected edge %0d pulse %b toggle %b held %b",
               tag, edge_cnt, p, t, h, e.at_edge, e.pulse, e.toggle, e.held);
    end
  endtask

  task automatic push0(input int unsigned e, input logic [1:0] p, input logic [1:0] t, input logic [1:0] h);
    exp_t x;
    x.at_edge = e; x.pulse = p; x.toggle = t; x.held = h;
    q0.push_back(x);
  endtask

  task automatic push1(input int unsigned e, input logic [1:0] p, input logic [1:0] t, input logic [1:0] h);
    exp_t x;
    x.at_edge = e; x.pulse = p; x.toggle = t; x.held = h;
    q1.push_back(x);
  endtask

  // Monitor for the non-repeating instance.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0 && q0[0].at_edge < edge_cnt) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut0_missed: no pulse at edge %0d, expected pulse %b", q0[0].at_edge, q0[0].pulse);
      void'(q0.pop_front());
    end
    if (pulse0 !== 2'b00) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut0_unexpected: pulse %b at edge %0d, expected none", pulse0, edge_cnt);
      end else begin
        e = q0.pop_front();
        cmp_pulse("dut0", e, pulse0, tog0, held0);
      end
    end
  end

  // Monitor for the auto-repeat instance.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0 && q1[0].at_edge < edge_cnt) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut1_missed: no pulse at edge %0d, expected pulse %b", q1[0].at_edge, q1[0].pulse);
      void'(q1.pop_front());
    end
    if (pulse1 !== 2'b00) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected: pulse %b at edge %0d, expected none", pulse1, edge_cnt);
      end else begin
        e = q1.pop_front();
        cmp_pulse("dut1", e, pulse1, tog1, held1);
      end
    end
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    btn0 = 2'b11; btn1 = 2'b11;
    clr0 = 2'b00; clr1 = 2'b00;
    tick(3);
    chk("reset0", {pulse0, tog0, held0}, 6'b0);
    chk("reset1", {pulse1, tog1, held1}, 6'b0);
    rst0 = 1'b0; rst1 = 1'b0;

    // Idle buttons: no pulses for 20 cycles.
    tick(20);
    chk("idle_hold", {pulse0, tog0, held0}, 6'b0);

    // Clean press on channel 0: pulse after edge 6.
    t0 = edge_cnt;
    btn0[0] = 1'b0;
    push0(t0 + 7, 2'b01, 2'b01, 2'b01);
    tick(10);
    chk("press_state", {pulse0, tog0, held0}, 6'b00_01_01);
    btn0[0] = 1'b1;
    tick(12);
    chk("release_state", {pulse0, tog0, held0}, 6'b00_01_00);

    // Short glitch is rejected.
    btn0[0] = 1'b0;
    tick(2);
    btn0[0] = 1'b1;
    tick(12);
    chk("glitch_reject", {pulse0, tog0, held0}, 6'b00_01_00);

    // Press, then bounce during release debounce: held stays high.
    t0 = edge_cnt;
    btn0[0] = 1'b0;
    push0(t0 + 7, 2'b01, 2'b00, 2'b01);
    tick(10);
    btn0[0] = 1'b1;
    tick(3);
    btn0[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk("bounce_held_low", {4'b0, held0}, 6'b00_00_01);
    end
    btn0[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("bounce_held_high", {4'b0, held0}, 6'b00_00_01);
    end
    tick(12);
    chk("bounce_done", {pulse0, tog0, held0}, 6'b00_00_00);

    // Channel 1: two presses toggle 1 then 0, third press with clear stays 0.
    for (int k = 0; k < 3; k++) begin
      t0 = edge_cnt;
      btn0[1] = 1'b0;
      push0(t0 + 7, 2'b10, (k == 0) ? 2'b10 : 2'b00, 2'b10);
      if (k == 2) begin
        tick(6);
        clr0[1] = 1'b1;
        tick(1);
        clr0[1] = 1'b0;
        tick(3);
      end else begin
        tick(10);
      end
      btn0[1] = 1'b1;
      tick(12);
    end
    chk("clr_wins", {pulse0, tog0, held0}, 6'b00_00_00);

    // Reset while pressed aborts, then a full debounce is required.
    t0 = edge_cnt;
    btn0[0] = 1'b0;
    push0(t0 + 7, 2'b01, 2'b01, 2'b01);
    tick(10);
    rst0 = 1'b1;
    tick(1);
    chk("reset_mid_press", {pulse0, tog0, held0}, 6'b0);
    rst0 = 1'b0;
    t0 = edge_cnt;
    push0(t0 + 7, 2'b01, 2'b01, 2'b01);
    tick(10);
    btn0[0] = 1'b1;
    tick(12);

    // Auto-repeat: first pulse at edge 6, repeats every 3 from edge 16.
    t0 = edge_cnt;
    btn1[0] = 1'b0;
    push1(t0 + 7, 2'b01, 2'b01, 2'b01);
    for (int k = 17; k <= 32; k += 3)
      push1(t0 + k, 2'b01, 2'b01, 2'b01);
    tick(30);
    btn1[0] = 1'b1;
    tick(14);
    chk("repeat_done", {pulse1, tog1, held1}, 6'b00_01_00);

    tick(4);
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL pending_pulses: %0d/%0d left, expected 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
